// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
//   in_valid / in_data / in_ready : valid/ready byte stream into the loader
//   wr_en / wr_addr / wr_data     : write strobe, address and data toward instruction memory
// slave  : the loader (consumes the stream, drives the write bus)
// master : the environment (drives the stream, observes the write bus)
interface program_loader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (length, payload, checksum)
// and writes the payload into instruction memory from address 0, holding the
// CPU halted while loading and reporting done or error at the end of a frame.
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_start        : one-cycle pulse that begins a load from IDLE/DONE/ERR
//   bus            : byte stream in, instruction-memory write bus out
//   o_cpu_hold     : CPU halt request
//   o_done         : last load succeeded
//   o_error        : last load failed
//   o_loaded_count : payload bytes written in the current or last load
module program_loader #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 11
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    program_loader_if.slave bus,
    output logic            o_cpu_hold,
    output logic            o_done,
    output logic            o_error,
    output logic [ADDR_W:0] o_loaded_count
);
    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(2 ** ADDR_W);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t            r_state,    w_state_nx;
    logic              r_in_ready, w_in_ready_nx;
    logic              r_wr_en,    w_wr_en_nx;
    logic [ADDR_W-1:0] r_wr_addr,  w_wr_addr_nx;
    logic [DATA_W-1:0] r_wr_data,  w_wr_data_nx;
    logic              r_cpu_hold, w_cpu_hold_nx;
    logic              r_done,     w_done_nx;
    logic              r_error,    w_error_nx;
    logic [CNT_W-1:0]  r_count,    w_count_nx;
    logic [CNT_W-1:0]  r_len,      w_len_nx;
    logic [DATA_W-1:0] r_sum,      w_sum_nx;
    logic [TO_W-1:0]   r_to_cnt,   w_to_cnt_nx;
    logic              w_xfer;
    logic              w_active;
    logic              w_fail;
    logic [CNT_W-1:0]  w_count_inc;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_active    = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nx    = r_state;
        w_in_ready_nx = r_in_ready;
        w_wr_en_nx    = 1'b0;
        w_wr_addr_nx  = r_wr_addr;
        w_wr_data_nx  = r_wr_data;
        w_cpu_hold_nx = r_cpu_hold;
        w_done_nx     = r_done;
        w_error_nx    = r_error;
        w_count_nx    = r_count;
        w_len_nx      = r_len;
        w_sum_nx      = r_sum;
        w_to_cnt_nx   = r_to_cnt;
        w_fail        = 1'b0;

        // Idle-cycle watchdog; a transfer in the same cycle takes precedence
        if (w_active) begin
            if (w_xfer) begin
                w_to_cnt_nx = '0;
            end else if (r_to_cnt == TO_LAST) begin
                w_fail = 1'b1;
            end else begin
                w_to_cnt_nx = r_to_cnt + TO_W'(1);
            end
        end

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_state_nx    = S_LEN;
                    w_done_nx     = 1'b0;
                    w_error_nx    = 1'b0;
                    w_count_nx    = '0;
                    w_sum_nx      = '0;
                    w_to_cnt_nx   = '0;
                    w_cpu_hold_nx = 1'b1;
                    w_in_ready_nx = 1'b1;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    if ((bus.in_data == '0) || (bus.in_data > MAX_LEN)) begin
                        w_fail = 1'b1;
                    end else begin
                        w_len_nx   = CNT_W'(bus.in_data);
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Payload address equals the number of bytes already written
                if (w_xfer) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_addr_nx = r_count[ADDR_W-1:0];
                    w_wr_data_nx = bus.in_data;
                    w_sum_nx     = r_sum + bus.in_data;
                    w_count_nx   = w_count_inc;
                    if (w_count_inc == r_len) begin
                        w_state_nx = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (bus.in_data == r_sum) begin
                        w_state_nx    = S_DONE;
                        w_done_nx     = 1'b1;
                        w_cpu_hold_nx = 1'b0;
                        w_in_ready_nx = 1'b0;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Any failure parks in ERR with the CPU still held
        if (w_fail) begin
            w_state_nx    = S_ERR;
            w_error_nx    = 1'b1;
            w_done_nx     = 1'b0;
            w_in_ready_nx = 1'b0;
            w_cpu_hold_nx = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
            r_len      <= '0;
            r_sum      <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= w_in_ready_nx;
            r_wr_en    <= w_wr_en_nx;
            r_wr_addr  <= w_wr_addr_nx;
            r_wr_data  <= w_wr_data_nx;
            r_cpu_hold <= w_cpu_hold_nx;
            r_done     <= w_done_nx;
            r_error    <= w_error_nx;
            r_count    <= w_count_nx;
            r_len      <= w_len_nx;
            r_sum      <= w_sum_nx;
            r_to_cnt   <= w_to_cnt_nx;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_loaded_count = r_count;
endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed and random frames driven through the
// interface, with expected writes and outcome computed from the frame itself.
module tb_program_loader;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned TO_W    = 11;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [ADDR_W:0] loaded_count;

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    program_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .bus(bus),
        .o_cpu_hold(cpu_hold),
        .o_done(done),
        .o_error(error),
        .o_loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit noise_en = 1'b0;

    logic [7:0] frame_q[$];
    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    int xc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with the edge that produced it
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wa_q.push_back(int'(bus.wr_addr));
            wd_q.push_back(int'(bus.wr_data));
            wc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); xc_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(loaded_count), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns at the negedge after the transfer
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_payload);
        int waited;
        waited = 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        start = noise_en && ($urandom_range(0, 3) == 0);
        while (!bus.in_ready && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("ready_wait", 32'(bus.in_ready), 32'd1);
        end else if (is_payload) begin
            xc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    // Run frame_q as one load and compare against what the frame should produce
    task automatic run_frame(input int max_gap, input int big_gap_idx);
        int len, n, s, n_exp, gap;
        bit bad_len, ok;
        clear_log();
        pulse_start();
        check("st_hold", 32'(cpu_hold), 32'd1);
        check("st_done", 32'(done), 32'd0);
        check("st_error", 32'(error), 32'd0);
        check("st_count", 32'(loaded_count), 32'd0);
        check("st_ready", 32'(bus.in_ready), 32'd1);

        len = int'(frame_q[0]);
        bad_len = (len == 0) || (len > 16);
        n = bad_len ? 1 : len + 2;
        for (int i = 0; i < n; i++) begin
            gap = (i == big_gap_idx) ? int'(TIMEOUT) - 1 : int'($urandom_range(0, max_gap));
            send_byte(frame_q[i], gap, (i >= 1) && (i <= len));
        end

        s = 0;
        if (!bad_len) begin
            for (int i = 1; i <= len; i++) s = (s + int'(frame_q[i])) % 256;
        end
        ok = !bad_len && (int'(frame_q[len + 1]) == s);
        n_exp = bad_len ? 0 : len;

        check("end_done", 32'(done), 32'(ok));
        check("end_error", 32'(error), 32'(!ok));
        check("end_hold", 32'(cpu_hold), 32'(!ok));
        check("end_ready", 32'(bus.in_ready), 32'd0);
        check("end_excl", 32'(done & error), 32'd0);
        check("end_count", 32'(loaded_count), 32'(n_exp));

        repeat (3) @(negedge clk);
        check("wr_cnt", 32'(wa_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < wa_q.size(); i++) begin
            check("wr_addr", 32'(wa_q[i]), 32'(i));
            check("wr_data", 32'(wd_q[i]), 32'(frame_q[i + 1]));
            if (i < xc_q.size()) check("wr_lat", 32'(wc_q[i]), 32'(xc_q[i]));
        end
    endtask

    task automatic set_case1();
        frame_q = '{8'h08, 8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'hF8, 8'hCB, 8'hA7, 8'h78, 8'hA8};
    endtask

    initial begin
        int len, s;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back good frame
        set_case1();
        run_frame(0, -1);

        // Bad checksum, then a clean reload
        set_case1();
        frame_q[9] = 8'hA9;
        run_frame(0, -1);
        set_case1();
        run_frame(0, -1);

        // Illegal lengths
        frame_q = '{8'h00};
        run_frame(0, -1);
        frame_q = '{8'h11};
        run_frame(0, -1);

        // Full 16-byte frame, no address wrap
        frame_q = '{8'h10};
        for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
        frame_q.push_back(8'h78);
        run_frame(0, -1);

        // Gapped stream including one gap of TIMEOUT-1
        set_case1();
        run_frame(3, 4);

        // Stall of exactly TIMEOUT cycles mid-payload
        clear_log();
        pulse_start();
        send_byte(8'h08, 0, 1'b0);
        for (int i = 1; i <= 3; i++) send_byte(8'(8'h10 + i), 0, 1'b1);
        repeat (int'(TIMEOUT) - 1) @(negedge clk);
        check("to_before", 32'(error), 32'd0);
        @(negedge clk);
        check("to_error", 32'(error), 32'd1);
        check("to_done", 32'(done), 32'd0);
        check("to_hold", 32'(cpu_hold), 32'd1);
        check("to_ready", 32'(bus.in_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("to_wr_cnt", 32'(wa_q.size()), 32'd3);

        // Reset after three payload bytes
        clear_log();
        pulse_start();
        send_byte(8'h05, 0, 1'b0);
        for (int i = 1; i <= 3; i++) send_byte(8'(8'h40 + i), 0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wr_cnt", 32'(wa_q.size()), 32'd3);
        set_case1();
        run_frame(0, -1);

        // Random frames, with stray start pulses mid-frame
        noise_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 5) == 0) begin
                frame_q = '{8'($urandom_range(17, 255))};
            end else begin
                len = int'($urandom_range(1, 16));
                frame_q = '{8'(len)};
                s = 0;
                for (int i = 0; i < len; i++) begin
                    frame_q.push_back(8'($urandom_range(0, 255)));
                    s = (s + int'(frame_q[i + 1])) % 256;
                end
                if ($urandom_range(0, 1) == 0) s = (s + int'($urandom_range(1, 255))) % 256;
                frame_q.push_back(8'(s));
            end
            run_frame(2, -1);
        end
        noise_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer side of the CPU's 16x8 instruction store. Accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and issues sequential write strobes into instruction memory from address 0. Holds the CPU in halt while loading. Reports done or error when the frame ends.

Parameters:
ADDR_W, 4, instruction memory address width; depth = 2^ADDR_W (16).
DATA_W, 8, instruction/byte width; checksum width is the same.
TIMEOUT, 1024, max cycles with no accepted byte while loading before error.
TO_W, 11, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
in_valid  in  1  source has a byte on in_data.
in_data  in  DATA_W  stream byte.
in_ready  out  1  loader can accept a byte (registered).
wr_en  out  1  instruction memory write strobe (registered).
wr_addr  out  ADDR_W  write address.
wr_data  out  DATA_W  write data.
cpu_hold  out  1  keeps the CPU halted while high.
done  out  1  last load succeeded (level).
error  out  1  last load failed (level).
loaded_count  out  ADDR_W+1  payload bytes written in the current or last load.

Behaviour:
- Reset: state IDLE. in_ready, wr_en, cpu_hold, done, error = 0. wr_addr, wr_data, loaded_count = 0. Checksum accumulator and timeout counter cleared. Reset mid-load aborts the load at once; no further wr_en.
- Transfer occurs on a cycle where in_valid && in_ready. in_data is sampled only on a transfer.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN on the next edge. Same edge: done=0, error=0, loaded_count=0, sum=0, cpu_hold=1, in_ready=1. start is ignored in LEN/DATA/CSUM.
- LEN transfer:
  - Byte 0 or > 2^ADDR_W (0x10 here): -> ERR.
  - Otherwise: remaining=byte, addr=0 -> DATA.
- DATA transfer:
  - Next edge: wr_en=1 for exactly one cycle, wr_addr=current addr, wr_data=byte. This is a 1-cycle write latency.
  - sum = (sum + byte) mod 2^DATA_W. addr+1. loaded_count+1.
  - After the last byte -> CSUM. The write address never wraps past 2^ADDR_W-1.
- Back-to-back transfers are allowed: one byte per cycle, so wr_en may stay high for consecutive cycles.
- CSUM transfer:
  - byte == sum -> DONE: done=1, cpu_hold=0, in_ready=0.
  - byte != sum -> ERR: error=1, cpu_hold stays 1, in_ready=0. Memory already written is not rolled back.
- Timeout:
  - Counter runs in LEN/DATA/CSUM, resets on every transfer.
  - Reaching TIMEOUT consecutive non-transfer cycles -> ERR.
  - In the transfer cycle itself, the transfer wins over the timeout.
- In ERR: in_ready=0, error=1, cpu_hold=1 until the next start or rst.
- done and error are never high together.

Test Plan:
1. start; stream 08, A6 AF B4 BD F8 CB A7 78, A8 back-to-back -> 8 consecutive wr_en pulses at addr 0..7 with those bytes. Then done=1, error=0, cpu_hold 1->0, loaded_count=8.
2. Same frame with checksum A9 -> 8 writes, then error=1, done=0, cpu_hold=1. A later start clears error and reloads cleanly.
3. Length 00, and separately 11 -> ERR on the cycle after the length transfer. No wr_en ever; loaded_count=0.
4. Length 10 with 16 bytes 00..0F, checksum 78 -> writes addr 0..15, no wrap. loaded_count=16, done=1.
5. Random in_valid gaps of at most TIMEOUT-1 cycles -> success as in case 1. Then a stall of TIMEOUT cycles mid-DATA -> error=1, no further writes.
6. rst asserted after 3 DATA bytes -> next cycle all outputs at reset values. A new start plus a full frame writes from addr 0 and ends with done=1.
